// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: multi-channel external bus controller with fixed-priority or
// round-robin arbitration, programmable data-phase wait states and a ready
// line. Every output is a register updated on the rising edge of clk.
module io_bus_ctrl #(
    parameter int unsigned NCH  = 2,
    parameter int unsigned DW   = 16,
    parameter int unsigned AW   = 20,
    parameter int unsigned WAIT = 0,
    parameter int unsigned RR   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    rw,
    input  logic [NCH-1:0]    mio,
    input  logic [NCH*AW-1:0] adr,
    input  logic [NCH*DW-1:0] dtw,
    output logic [NCH-1:0]    ack,
    output logic [DW-1:0]     dtr,
    input  logic [DW-1:0]     din,
    input  logic              rdy,
    output logic [DW-1:0]     dout,
    output logic [AW-DW-1:0]  adr_hi,
    output logic              ale,
    output logic              oe,
    output logic              we,
    output logic              pio,
    output logic              isout
);

    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     last_q, last_d;
    logic              rw_q, rw_d;
    logic [DW-1:0]     dtw_q, dtw_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NCH-1:0]    ack_q, ack_d;
    logic [DW-1:0]     dtr_q, dtr_d;
    logic [DW-1:0]     dout_q, dout_d;
    logic [AW-DW-1:0]  adr_hi_q, adr_hi_d;
    logic              ale_q, ale_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              pio_q, pio_d;
    logic              isout_q, isout_d;

    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic              found;

    // Arbiter: pick the channel to grant from the current request vector.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        if (RR != 0) begin
            for (int unsigned off = 1; off <= NCH; off++) begin
                cand = IW'((int'(last_q) + off) % NCH);
                if (!found && req[cand]) begin
                    pick  = cand;
                    found = 1'b1;
                end
            end
        end else begin
            // Later iterations overwrite earlier ones, so the highest index wins.
            for (int unsigned i = 0; i < NCH; i++) begin
                if (req[i]) pick = IW'(i);
            end
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        rw_d     = rw_q;
        dtw_d    = dtw_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        dtr_d    = dtr_q;
        dout_d   = dout_q;
        adr_hi_d = adr_hi_q;
        ale_d    = ale_q;
        oe_d     = oe_q;
        we_d     = we_q;
        pio_d    = pio_q;
        isout_d  = isout_q;
        unique case (state_q)
            StIdle: begin
                ale_d   = 1'b0;
                oe_d    = 1'b0;
                we_d    = 1'b0;
                isout_d = 1'b0;
                if (|req) begin
                    grant_d  = pick;
                    last_d   = pick;
                    rw_d     = rw[pick];
                    dtw_d    = dtw[pick*DW +: DW];
                    dout_d   = adr[pick*AW +: DW];
                    adr_hi_d = adr[pick*AW + DW +: AW-DW];
                    pio_d    = mio[pick];
                    ale_d    = 1'b1;
                    isout_d  = 1'b1;
                    state_d  = StAddr;
                end
            end
            StAddr: begin
                ale_d = 1'b0;
                cnt_d = 4'(WAIT);
                if (rw_q) begin
                    we_d    = 1'b1;
                    isout_d = 1'b1;
                    dout_d  = dtw_q;
                end else begin
                    oe_d    = 1'b1;
                    isout_d = 1'b0;
                end
                state_d = StData;
            end
            StData: begin
                // rdy only matters once the minimum wait count has expired.
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (rdy) begin
                    oe_d           = 1'b0;
                    we_d           = 1'b0;
                    isout_d        = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    if (!rw_q) dtr_d = din;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            last_q   <= IW'(NCH - 1);
            rw_q     <= 1'b0;
            dtw_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            dtr_q    <= '0;
            dout_q   <= '0;
            adr_hi_q <= '0;
            ale_q    <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            pio_q    <= 1'b1;
            isout_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            rw_q     <= rw_d;
            dtw_q    <= dtw_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            dtr_q    <= dtr_d;
            dout_q   <= dout_d;
            adr_hi_q <= adr_hi_d;
            ale_q    <= ale_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            pio_q    <= pio_d;
            isout_q  <= isout_d;
        end
    end

    assign ack    = ack_q;
    assign dtr    = dtr_q;
    assign dout   = dout_q;
    assign adr_hi = adr_hi_q;
    assign ale    = ale_q;
    assign oe     = oe_q;
    assign we     = we_q;
    assign pio    = pio_q;
    assign isout  = isout_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed testbench for io_bus_ctrl. Three instances cover the parameter
// sets needed: A (NCH=2, WAIT=0, fixed), B (NCH=2, WAIT=2, fixed) and
// C (NCH=4, WAIT=1, round-robin). Inputs change and outputs are sampled on
// the falling edge; "cycle n" is the falling edge after the n-th rising edge
// counted from the grant edge.
module tb_io_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A
    logic [1:0]  a_req, a_rw, a_mio, a_ack;
    logic [39:0] a_adr;
    logic [31:0] a_dtw;
    logic [15:0] a_dtr, a_din, a_dout;
    logic [3:0]  a_adr_hi;
    logic        a_rdy, a_ale, a_oe, a_we, a_pio, a_isout;

    // Instance B
    logic [1:0]  b_req, b_rw, b_mio, b_ack;
    logic [39:0] b_adr;
    logic [31:0] b_dtw;
    logic [15:0] b_dtr, b_din, b_dout;
    logic [3:0]  b_adr_hi;
    logic        b_rdy, b_ale, b_oe, b_we, b_pio, b_isout;

    // Instance C
    logic [3:0]  c_req, c_rw, c_mio, c_ack;
    logic [79:0] c_adr;
    logic [63:0] c_dtw;
    logic [15:0] c_dtr, c_din, c_dout;
    logic [3:0]  c_adr_hi;
    logic        c_rdy, c_ale, c_oe, c_we, c_pio, c_isout;

    io_bus_ctrl #(.NCH(2), .DW(16), .AW(20), .WAIT(0), .RR(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .rw(a_rw), .mio(a_mio), .adr(a_adr),
        .dtw(a_dtw), .ack(a_ack), .dtr(a_dtr), .din(a_din), .rdy(a_rdy), .dout(a_dout),
        .adr_hi(a_adr_hi), .ale(a_ale), .oe(a_oe), .we(a_we), .pio(a_pio), .isout(a_isout)
    );

    io_bus_ctrl #(.NCH(2), .DW(16), .AW(20), .WAIT(2), .RR(0)) u_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .rw(b_rw), .mio(b_mio), .adr(b_adr),
        .dtw(b_dtw), .ack(b_ack), .dtr(b_dtr), .din(b_din), .rdy(b_rdy), .dout(b_dout),
        .adr_hi(b_adr_hi), .ale(b_ale), .oe(b_oe), .we(b_we), .pio(b_pio), .isout(b_isout)
    );

    io_bus_ctrl #(.NCH(4), .DW(16), .AW(20), .WAIT(1), .RR(1)) u_c (
        .clk(clk), .rst_n(rst_n), .req(c_req), .rw(c_rw), .mio(c_mio), .adr(c_adr),
        .dtw(c_dtw), .ack(c_ack), .dtr(c_dtr), .din(c_din), .rdy(c_rdy), .dout(c_dout),
        .adr_hi(c_adr_hi), .ale(c_ale), .oe(c_oe), .we(c_we), .pio(c_pio), .isout(c_isout)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({a_ale, a_oe, a_we, a_isout, a_pio} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00001", {a_ale, a_oe, a_we, a_isout, a_pio});
        end
        checks++;
        if ({a_ack, a_dtr, a_dout, a_adr_hi} !== '0) begin
            errors++;
            $display("FAIL reset_data: got ack=%b dtr=%h dout=%h adr_hi=%h want all 0",
                     a_ack, a_dtr, a_dout, a_adr_hi);
        end
    endtask

    task automatic test_single_read();
        a_adr[19:0] = 20'h51234;
        a_rw = 2'b00;
        a_mio = 2'b01;
        a_din = 16'hBEEF;
        a_req = 2'b01;
        cyc();
        checks++;
        if ({a_ale, a_isout, a_pio, a_dout, a_adr_hi} !== {3'b111, 16'h1234, 4'h5}) begin
            errors++;
            $display("FAIL read_addr: got ale=%b isout=%b pio=%b dout=%h adr_hi=%h want 1 1 1 1234 5",
                     a_ale, a_isout, a_pio, a_dout, a_adr_hi);
        end
        cyc();
        checks++;
        if ({a_ale, a_oe, a_we, a_isout, a_ack} !== 6'b010000) begin
            errors++;
            $display("FAIL read_data: got ale=%b oe=%b we=%b isout=%b ack=%b want 0 1 0 0 00",
                     a_ale, a_oe, a_we, a_isout, a_ack);
        end
        cyc();
        checks++;
        if ({a_ack, a_oe, a_dtr} !== {2'b01, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL read_done: got ack=%b oe=%b dtr=%h want 01 0 beef", a_ack, a_oe, a_dtr);
        end
        a_req = 2'b00;
        cyc();
        cyc();
        checks++;
        if ({a_ack, a_ale, a_dtr} !== {2'b00, 1'b0, 16'hBEEF}) begin
            errors++;
            $display("FAIL read_idle: got ack=%b ale=%b dtr=%h want 00 0 beef", a_ack, a_ale, a_dtr);
        end
    endtask

    task automatic test_contention();
        int t0 = 0;
        int t1 = 0;
        int multi = 0;
        a_adr = {20'h20000, 20'h10000};
        a_rw = 2'b00;
        a_req = 2'b11;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (c == 1) begin
                checks++;
                if (a_adr_hi !== 4'h2) begin
                    errors++;
                    $display("FAIL contention_first_grant: got adr_hi=%h want 2", a_adr_hi);
                end
            end
            if (a_ack == 2'b11) multi++;
            if (a_ack[1]) begin t1 = c; a_req[1] = 1'b0; end
            if (a_ack[0]) begin t0 = c; a_req[0] = 1'b0; end
        end
        checks++;
        if (t1 != 3 || t0 != 7) begin
            errors++;
            $display("FAIL contention_order: got ack1@%0d ack0@%0d want 3 7", t1, t0);
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL contention_onehot: got %0d multi-bit acks want 0", multi);
        end
    endtask

    task automatic test_single_write();
        int we_cycles = 0;
        int bad = 0;
        int t_ack = 0;
        logic [1:0] ack_val = '0;
        b_adr[39:20] = 20'hA0010;
        b_dtw[31:16] = 16'h55AA;
        b_rw = 2'b10;
        b_mio = 2'b00;
        b_din = 16'h1111;
        b_req = 2'b10;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) begin
                checks++;
                if ({b_ale, b_pio, b_dout, b_adr_hi} !== {2'b10, 16'h0010, 4'hA}) begin
                    errors++;
                    $display("FAIL write_addr: got ale=%b pio=%b dout=%h adr_hi=%h want 1 0 0010 a",
                             b_ale, b_pio, b_dout, b_adr_hi);
                end
            end
            if (b_we) begin
                we_cycles++;
                if (b_dout !== 16'h55AA || b_isout !== 1'b1 || b_oe !== 1'b0) bad++;
            end
            if (b_ack != 2'b00 && t_ack == 0) begin
                t_ack = c;
                ack_val = b_ack;
                b_req = 2'b00;
            end
        end
        checks++;
        if (we_cycles != 3 || bad != 0) begin
            errors++;
            $display("FAIL write_strobe: got we_cycles=%0d bad=%0d want 3 0", we_cycles, bad);
        end
        checks++;
        if (t_ack != 5 || ack_val !== 2'b10) begin
            errors++;
            $display("FAIL write_ack: got cycle=%0d ack=%b want 5 10", t_ack, ack_val);
        end
        checks++;
        if (b_dtr !== 16'h0000) begin
            errors++;
            $display("FAIL write_dtr: got %h want 0000", b_dtr);
        end
    endtask

    task automatic test_reset_mid();
        int early_ack = 0;
        int t_ack = 0;
        b_adr[19:0] = 20'h30040;
        b_dtw[15:0] = 16'h1234;
        b_rw = 2'b01;
        b_mio = 2'b01;
        b_req = 2'b01;
        cyc();
        cyc();
        checks++;
        if (b_we !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got we=%b want 1", b_we);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({b_we, b_isout, b_ale, b_pio, b_dout, b_adr_hi} !== {4'b0001, 16'h0, 4'h0}) begin
            errors++;
            $display("FAIL rst_mid_async: got we=%b isout=%b ale=%b pio=%b dout=%h adr_hi=%h want 0 0 0 1 0 0",
                     b_we, b_isout, b_ale, b_pio, b_dout, b_adr_hi);
        end
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (b_ack != 2'b00 || b_we) early_ack++;
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) begin
                checks++;
                if ({b_ale, b_dout, b_adr_hi} !== {1'b1, 16'h0040, 4'h3}) begin
                    errors++;
                    $display("FAIL rst_mid_restart: got ale=%b dout=%h adr_hi=%h want 1 0040 3",
                             b_ale, b_dout, b_adr_hi);
                end
            end
            if (b_ack == 2'b01 && t_ack == 0) begin
                t_ack = c;
                b_req = 2'b00;
            end
        end
        checks++;
        if (early_ack != 0 || t_ack != 5) begin
            errors++;
            $display("FAIL rst_mid_ack: got acks_in_reset=%0d ack_cycle=%0d want 0 5", early_ack, t_ack);
        end
    endtask

    task automatic test_round_robin();
        int order[5];
        int n = 0;
        int multi = 0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [3:0] raise = '0;
        c_rw = 4'b0000;
        c_req = 4'b1111;
        for (int c = 1; c <= 60 && n < 5; c++) begin
            cyc();
            c_req = c_req | raise;
            raise = '0;
            if (!$onehot0(c_ack)) multi++;
            for (int i = 0; i < 4; i++) begin
                if (c_ack[i] && n < 5) begin
                    order[n] = i;
                    n++;
                    c_req[i] = 1'b0;
                    raise[i] = 1'b1;
                end
            end
        end
        c_req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= n || order[i] != exp_order[i]) begin
                errors++;
                $display("FAIL rr_order_%0d: got %0d (acks seen %0d) want %0d",
                         i, (i < n) ? order[i] : -1, n, exp_order[i]);
            end
        end
        checks++;
        if (multi != 0) begin
            errors++;
            $display("FAIL rr_onehot: got %0d bad ack cycles want 0", multi);
        end
        cyc();
        cyc();
    endtask

    task automatic test_ready_stretch();
        int oe_cycles = 0;
        int t_ack = 0;
        logic [3:0] ack_val = '0;
        logic [15:0] dtr_val = '0;
        c_adr[59:40] = 20'h7ABCD;
        c_rw = 4'b0000;
        c_din = 16'h0F0F;
        c_rdy = 1'b0;
        c_req = 4'b0100;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            if (c_oe) oe_cycles++;
            if (c_ack != 4'b0000 && t_ack == 0) begin
                t_ack = c;
                ack_val = c_ack;
                dtr_val = c_dtr;
                c_req = 4'b0000;
            end
            if (c == 8) begin
                c_rdy = 1'b1;
                c_din = 16'hCAFE;
            end
        end
        checks++;
        if (oe_cycles != 7) begin
            errors++;
            $display("FAIL stretch_oe: got %0d oe cycles want 7", oe_cycles);
        end
        checks++;
        if (t_ack != 9 || ack_val !== 4'b0100 || dtr_val !== 16'hCAFE) begin
            errors++;
            $display("FAIL stretch_done: got cycle=%0d ack=%b dtr=%h want 9 0100 cafe",
                     t_ack, ack_val, dtr_val);
        end
    endtask

    initial begin
        a_req = '0; a_rw = '0; a_mio = '0; a_adr = '0; a_dtw = '0; a_din = '0; a_rdy = 1'b1;
        b_req = '0; b_rw = '0; b_mio = '0; b_adr = '0; b_dtw = '0; b_din = '0; b_rdy = 1'b1;
        c_req = '0; c_rw = '0; c_mio = '0; c_adr = '0; c_dtw = '0; c_din = '0; c_rdy = 1'b1;
        rst_n = 1'b0;
        cyc();
        cyc();
        test_reset();
        rst_n = 1'b1;
        cyc();
        test_single_read();
        test_contention();
        test_single_write();
        test_reset_mid();
        test_round_robin();
        test_ready_stretch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Parametrised external-bus controller and arbiter for the CPU core. It serves NCH requesters (instruction queue, execution engine, DMA, …) over one multiplexed address/data bus. Arbitration is selectable: fixed priority or round-robin. The data phase length is programmable and can be stretched by an external ready line. All outputs are registered on the rising edge; there are no negedge half-cycle strobes.

## Interface
Parameters:
- NCH, 2, number of requesting channels (1..8)
- DW, 16, data bus width
- AW, 20, address width; must be > DW, upper AW-DW bits go out on `adr_hi`
- WAIT, 0, minimum extra data-phase cycles (0..15)
- RR, 0, 0 = fixed priority (highest channel index wins), 1 = round-robin

Ports (NCH-wide buses are packed, channel i at slice i):
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NCH  per-channel request; held until that channel's ack
- rw  in  NCH  1 = write, 0 = read
- mio  in  NCH  1 = memory space, 0 = port-IO space
- adr  in  NCH*AW  per-channel address
- dtw  in  NCH*DW  per-channel write data
- ack  out  NCH  one-cycle completion pulse, one-hot or zero
- dtr  out  DW  last read data, shared by all channels
- din  in  DW  external bus input
- rdy  in  1  external ready; 0 stretches the data phase
- dout  out  DW  external bus output (address low, then write data)
- adr_hi  out  AW-DW  upper address bits
- ale  out  1  address latch enable, high for the ADDR cycle
- oe  out  1  read strobe
- we  out  1  write strobe
- pio  out  1  space select of the current transfer (1 = memory)
- isout  out  1  bus direction, 1 = controller drives `dout`

## Operation
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - Outputs: ale=oe=we=isout=0, ack=0.
  - If any req is high: pick a channel `g`. Register adr[g], rw[g], mio[g] and dtw[g]. Go to ADDR.
- ADDR (1 cycle):
  - ale=1, isout=1, dout=adr[DW-1:0], adr_hi=adr[AW-1:DW], pio=mio[g].
  - Load the wait counter with WAIT. Go to DATA.
- DATA:
  - Read: oe=1, isout=0.
  - Write: we=1, isout=1, dout=latched dtw.
  - adr_hi and pio are held.
  - While the counter is nonzero: decrement each cycle.
  - The phase ends at the first edge where counter==0 and rdy==1. On that edge, for a read, dtr<=din. Go to DONE.
- DONE (1 cycle):
  - oe=we=isout=0, ack[g]=1. Go to IDLE.
  - The requester drops req on the edge that ends DONE, so IDLE never re-grants a finished request.
- Fixed priority (RR=0): highest-indexed active req wins.
- Round-robin (RR=1):
  - Search starts at last_grant+1 modulo NCH.
  - last_grant updates only on grant.
  - Reset value NCH-1, so channel 0 wins first.
- Request drop: a req that falls after grant is ignored. The transfer completes and ack still pulses.
- dtr holds its value until the next completed read. Writes leave dtr unchanged.

## Timing
- Reset values: state IDLE, ack=0, dtr=0, dout=0, adr_hi=0, ale=oe=we=isout=0, pio=1, wait counter 0, last_grant=NCH-1.
- Reset is asynchronous. Asserting rst_n mid-transfer forces all reset values immediately, aborts the transfer, and produces no ack.
- Req high at edge k: ADDR outputs visible after edge k. DATA outputs visible after edge k+1.
- With rdy=1, DONE is visible after edge k+2+WAIT.
- One transfer = WAIT+3 cycles (ADDR + DATA + DONE), plus 1 IDLE cycle between transfers. Minimum rate: one transfer per WAIT+4 cycles.
- rdy is sampled only when the counter is 0. rdy low during the WAIT count-down has no effect.
- Simultaneous requests in IDLE resolve in the same cycle. Losers wait and keep req high.
- Exactly one ack bit may be high in any cycle.

## Test plan
- Single read, NCH=2, WAIT=0, ch0 adr=0x5_1234, din=0xBEEF:
  - ale=1 with dout=0x1234 and adr_hi=0x5 in cycle 1.
  - oe=1 in cycle 2.
  - ack[0]=1 in cycle 3, dtr=0xBEEF.
- Single write, ch1 adr=0xA_0010, dtw=0x55AA, WAIT=2:
  - we high for exactly 3 cycles with dout=0x55AA and isout=1.
  - ack[1] 5 cycles after grant; dtr unchanged.
- Contention, RR=0, ch0 and ch1 request together: ch1 acked first, ch0 acked 4 cycles later.
- Round-robin, NCH=4, RR=1, all four req held and re-raised after each ack: ack order 0,1,2,3,0.
- Ready stretch, WAIT=1, rdy held low for 5 cycles after the counter expires:
  - oe stays high for 7 cycles total.
  - dtr captures din from the first rdy=1 edge.
- Reset mid-DATA with a write in progress:
  - we, isout and ale fall asynchronously; no ack.
  - After release, a pending req restarts from ADDR.
